// File: rtl/vga_bounce_box.sv
// Pixel stage after the 640x480 timing generator: draws a bouncing square on a flat background.
// Define VGA_BORDER_EN to add a white one-pixel frame around the visible area.
module vga_bounce_box #(
    parameter int          H_ACTIVE  = 640,
    parameter int          V_ACTIVE  = 480,
    parameter int          BOX_SIZE  = 32,
    parameter int          STEP      = 2,
    parameter logic [11:0] BOX_COLOR = 12'hF00,
    parameter logic [11:0] BG_COLOR  = 12'h008
) (
    input  logic       clk_25,
    input  logic       rst,
    input  logic [9:0] x_count,
    input  logic [9:0] y_count,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       active_in,
    input  logic       pause,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       frame_tick
);

    typedef enum logic { DIR_POS, DIR_NEG } dir_t;

    typedef struct packed {
        logic [10:0] pos;
        dir_t        dir;
    } axis_t;

    localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - BOX_SIZE);
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] BOX_W  = 11'(BOX_SIZE);

    // One bounce step along an axis: clamp to the wall and reverse on contact.
    function automatic axis_t step_axis(input axis_t a, input logic [10:0] lim);
        axis_t r;
        r = a;
        if (a.dir == DIR_POS) begin
            if (a.pos >= lim - STEP_W) begin
                r.pos = lim;
                r.dir = DIR_NEG;
            end else begin
                r.pos = a.pos + STEP_W;
            end
        end else begin
            if (a.pos <= STEP_W) begin
                r.pos = '0;
                r.dir = DIR_POS;
            end else begin
                r.pos = a.pos - STEP_W;
            end
        end
        return r;
    endfunction

    axis_t ax, ay, ax_nxt, ay_nxt;
    logic  eof;
    logic  in_box;
    logic  [10:0] x_ext, y_ext;

    logic        s1_in_box, s1_active, s1_hsync, s1_vsync;
    logic [11:0] pix;

    assign eof   = (x_count == 10'd0) && (y_count == 10'(V_ACTIVE));
    assign x_ext = {1'b0, x_count};
    assign y_ext = {1'b0, y_count};

    always_comb begin
        ax_nxt = step_axis(ax, X_MAX);
        ay_nxt = step_axis(ay, Y_MAX);
    end

    // NOTE: all state uses non-blocking assignments so every register samples the same edge values.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            ax <= '{pos: X_MAX / 11'd2, dir: DIR_POS};
            ay <= '{pos: Y_MAX / 11'd2, dir: DIR_POS};
        end else if (eof && !pause) begin
            ax <= ax_nxt;
            ay <= ay_nxt;
        end
    end

    // The eof pixel uses the old position; it lies in blanking, so no tearing is visible.
    assign in_box = (x_ext >= ax.pos) && (x_ext < ax.pos + BOX_W) &&
                    (y_ext >= ay.pos) && (y_ext < ay.pos + BOX_W);

`ifdef VGA_BORDER_EN
    logic s1_border;

    always_ff @(posedge clk_25) begin
        if (rst) begin
            s1_border <= 1'b0;
        end else begin
            s1_border <= (x_count == 10'd0) || (x_count == 10'(H_ACTIVE - 1)) ||
                         (y_count == 10'd0) || (y_count == 10'(V_ACTIVE - 1));
        end
    end
`endif

    always_ff @(posedge clk_25) begin
        if (rst) begin
            s1_in_box  <= 1'b0;
            s1_active  <= 1'b0;
            s1_hsync   <= 1'b1;
            s1_vsync   <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            s1_in_box  <= in_box;
            s1_active  <= active_in;
            s1_hsync   <= hsync_in;
            s1_vsync   <= vsync_in;
            frame_tick <= eof;
        end
    end

    always_ff @(posedge clk_25) begin
        if (rst) begin
            pix       <= '0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            hsync_out <= s1_hsync;
            vsync_out <= s1_vsync;
            if (!s1_active) begin
                pix <= '0;
`ifdef VGA_BORDER_EN
            end else if (s1_border) begin
                pix <= 12'hFFF;
`endif
            end else if (s1_in_box) begin
                pix <= BOX_COLOR;
            end else begin
                pix <= BG_COLOR;
            end
        end
    end

    assign vga_r = pix[11:8];
    assign vga_g = pix[7:4];
    assign vga_b = pix[3:0];

endmodule
